// File: rtl/spike_train_gen_if.sv
// Load channel for spike_train_gen: a valid/ready handshake carrying the
// number of spikes to emit in the next train.
interface spike_train_gen_if #(
  parameter int size_code = 8
);
  logic                 load_valid;
  logic                 load_ready;
  logic [size_code-1:0] count_in;

  modport master (
    output load_valid,
    output count_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  count_in,
    output load_ready
  );
endinterface

// File: rtl/spike_train_gen.sv
// Spike train generator: after a count N is loaded, emits N one-cycle spikes
// on bitout separated by GAP idle cycles (enable low freezes the train), then
// pulses done for one cycle and returns to IDLE ready for the next count.
module spike_train_gen #(
  parameter int size_code = 8,
  parameter int GAP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  spike_train_gen_if.slave      lif,
  input  logic                  enable,
  output logic                  bitout,
  output logic [size_code-1:0]  remaining,
  output logic                  busy,
  output logic                  done
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_V = GW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [size_code-1:0] remaining_q, remaining_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 bitout_q, bitout_d;
  logic                 done_q, done_d;

  // Next-state logic: load in IDLE, spike/gap pacing in EMIT, done pulse from DONE.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    bitout_d    = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lif.load_valid) begin
          gap_d = '0;
          if (lif.count_in != '0) begin
            remaining_d = lif.count_in;
            state_d     = S_EMIT;
          end else begin
            // An empty train still produces its done pulse, just without spikes.
            remaining_d = '0;
            state_d     = S_DONE;
          end
        end
      end
      S_EMIT: begin
        if (enable) begin
          if (gap_q == '0) begin
            bitout_d    = 1'b1;
            remaining_d = remaining_q - size_code'(1);
            gap_d       = GAP_V;
            // remaining is never 0 in EMIT, so the decrement cannot wrap.
            if (remaining_q == size_code'(1)) begin
              state_d = S_DONE;
            end
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously so a reset aborts a train at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      gap_q       <= '0;
      bitout_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      bitout_q    <= bitout_d;
      done_q      <= done_d;
    end
  end

  assign lif.load_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign bitout         = bitout_q;
  assign remaining      = remaining_q;
  assign done           = done_q;

endmodule

// File: doc/spike_train_gen.md
SPIKE_TRAIN_GEN -- requirements
Module: spike_train_gen

Interface
REQ-001 The module SHALL take parameter size_code, default 8, as the width of the spike-count code.
REQ-002 The module SHALL take parameter GAP, default 1, as the number of idle cycles inserted between consecutive spikes; GAP >= 0.
REQ-003 Port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-005 Port load_valid  input  1  a new spike count is offered on count_in.
REQ-006 Port load_ready  output  1  the block can accept a count.
REQ-007 Port count_in  input  size_code  number of spikes to emit, unsigned.
REQ-008 Port enable  input  1  emission enable; low stalls emission.
REQ-009 Port bitout  output  1  registered spike output, one cycle high per spike.
REQ-010 Port remaining  output  size_code  spikes still to emit, registered.
REQ-011 Port busy  output  1  high whenever the state is not IDLE.
REQ-012 Port done  output  1  registered one-cycle pulse marking the end of a train.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, EMIT and DONE, plus an internal gap counter wide enough to hold GAP.
REQ-014 load_ready SHALL equal 1 only in IDLE; a load occurs on an edge where load_valid=1 and load_ready=1; count_in is sampled only at that edge.
REQ-015 On a load with count_in != 0: remaining<=count_in, gap counter<=0, state<=EMIT.
REQ-016 On a load with count_in == 0: state<=DONE and bitout stays 0, so no spike is emitted.
REQ-017 In EMIT, on an edge with enable=1 and gap counter=0: bitout<=1, remaining<=remaining-1, and gap counter<=GAP.
REQ-018 In EMIT, on an edge with enable=1 and gap counter>0: bitout<=0 and gap counter decrements by 1.
REQ-019 In EMIT with enable=0: bitout<=0, and remaining and the gap counter hold their values.
REQ-020 On the edge that emits the spike taking remaining from 1 to 0, state<=DONE.
REQ-021 In DONE, regardless of enable: on the next edge bitout<=0, done<=1 and state<=IDLE; done SHALL be 0 on every other edge.
REQ-022 The first spike appears on edge 1 after the load edge (edge 0).
REQ-023 Spike k (k=1..N) SHALL appear on edge 1+(k-1)(GAP+1) when enable stays 1; done is high after edge 2+(N-1)(GAP+1).
REQ-024 A load accepted in the IDLE cycle in which done=1 is legal; the new train SHALL proceed per REQ-015/016 with no extra cycle.
REQ-025 load_valid outside IDLE SHALL be ignored; count_in changes while busy SHALL NOT affect the train in progress.
REQ-026 count_in=2^size_code-1 SHALL emit exactly that many spikes; remaining SHALL never wrap below 0.

Reset
REQ-027 While reset=0: state=IDLE, bitout=0, done=0, busy=0, remaining=0, gap counter=0, load_ready=1.
REQ-028 Reset asserted mid-train SHALL abort the train immediately, with no further spikes and no done pulse.
REQ-029 After reset deasserts, the first load SHALL be accepted on the first rising edge with load_valid=1.

Verification (size_code=8, GAP=1)
REQ-030 Load 3 at edge 0, enable=1 -> bitout=1 after edges 1, 3 and 5 only; remaining 3,2,1,0; done=1 after edge 6 only; busy=0 from edge 6.
REQ-031 Load 0 -> bitout never 1; done=1 after edge 1; load_ready=1 after edge 1.
REQ-032 Load 4, enable=0 for 3 cycles right after the 2nd spike -> exactly 4 spikes, at edges 1, 3, 8 and 10; done after edge 11.
REQ-033 Load 10, pull reset low after the 2nd spike -> bitout, done, busy and remaining go to 0 asynchronously; no done pulse; load_ready=1.
REQ-034 Load 255 -> exactly 255 bitout pulses, each one cycle wide with one idle cycle between; a single done pulse follows.
REQ-035 Hold load_valid=1 with count_in=7 throughout a load of 2 -> the train emits 2 spikes; the 7 is accepted in the done cycle; 7 spikes follow, the first at the edge after acceptance.
